store_buffer: RTL

Write-buffered load/store front end that sits directly upstream of the data memory in the MEM stage. It accepts load/store requests from the pipeline, queues stores in a small FIFO, and drains them to the memory one per cycle when the memory port is idle. Loads get priority on the memory port and are forwarded from the youngest matching buffered store. Load data returns registered, one cycle after acceptance.

---
 rtl/store_buffer_if.sv | 28 ++
 rtl/store_buffer.sv | 105 ++++++++++
 2 files changed

// File: rtl/store_buffer_if.sv
// Request, load-return and data-memory signals of the MEM-stage store buffer.
interface store_buffer_if;
  logic        req_valid_i;
  logic        req_write_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        stall_o;
  logic        load_valid_o;
  logic [31:0] load_data_o;
  logic        empty_o;
  logic [31:0] mem_addr_o;
  logic        mem_write_o;
  logic        mem_read_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  modport master (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i, mem_rdata_i,
    input  stall_o, load_valid_o, load_data_o, empty_o,
    input  mem_addr_o, mem_write_o, mem_read_o, mem_wdata_o
  );

  modport slave (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, mem_rdata_i,
    output stall_o, load_valid_o, load_data_o, empty_o,
    output mem_addr_o, mem_write_o, mem_read_o, mem_wdata_o
  );
endinterface

// File: rtl/store_buffer.sv
// Store buffer: queues stores, drains one per idle memory cycle, loads have port priority.
// STORE_BUFFER_FWD_EN: forward loads from the youngest matching entry; else stall matching loads.
module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input logic         clk_i,
  input logic         rst_i,
  store_buffer_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [29:0]   r_addr [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_count;
  logic          r_load_valid;
  logic [31:0]   r_load_data;

  logic          w_store_req;
  logic          w_load_req;
  logic          w_full;
  logic          w_hit;
  logic          w_stall;
  logic          w_store_acc;
  logic          w_load_acc;
  logic          w_drain;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_load_result;
`ifdef STORE_BUFFER_FWD_EN
  logic [31:0]   w_fwd_data;
`endif

  assign w_store_req = bus.req_valid_i & bus.req_write_i;
  assign w_load_req  = bus.req_valid_i & ~bus.req_write_i;
  assign w_full      = (r_count == (AW+1)'(DEPTH));

  // Scan from tail-1 back toward head; the first hit is the youngest store.
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
`ifdef STORE_BUFFER_FWD_EN
    w_fwd_data = '0;
`endif
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_idx = r_tail - AW'(k + 1);
      if (!w_hit && ((AW+1)'(k) < r_count) && (r_addr[w_idx] == bus.req_addr_i[31:2])) begin
        w_hit = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
        w_fwd_data = r_data[w_idx];
`endif
      end
    end
  end

`ifdef STORE_BUFFER_FWD_EN
  assign w_stall       = w_store_req & w_full;
  assign w_load_result = w_hit ? w_fwd_data : bus.mem_rdata_i;
`else
  assign w_stall       = (w_store_req & w_full) | (w_load_req & w_hit);
  assign w_load_result = bus.mem_rdata_i;
`endif

  assign w_store_acc = w_store_req & ~w_stall;
  assign w_load_acc  = w_load_req & ~w_stall;
  assign w_drain     = (r_count != '0) & ~w_load_acc;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_load_valid <= 1'b0;
      r_load_data  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_store_acc) begin
        r_addr[r_tail] <= bus.req_addr_i[31:2];
        r_data[r_tail] <= bus.req_wdata_i;
        r_tail         <= r_tail + AW'(1);
      end
      if (w_drain) begin
        r_head <= r_head + AW'(1);
      end
      r_count      <= r_count + (AW+1)'(w_store_acc) - (AW+1)'(w_drain);
      r_load_valid <= w_load_acc;
      if (w_load_acc) begin
        r_load_data <= w_load_result;
      end
    end
  end

  assign bus.stall_o      = w_stall;
  assign bus.empty_o      = (r_count == '0);
  assign bus.load_valid_o = r_load_valid;
  assign bus.load_data_o  = r_load_data;
  assign bus.mem_read_o   = w_load_acc;
  assign bus.mem_write_o  = w_drain;
  assign bus.mem_addr_o   = w_load_acc ? bus.req_addr_i :
                            w_drain    ? {r_addr[r_head], 2'b00} : '0;
  assign bus.mem_wdata_o  = w_drain ? r_data[r_head] : '0;
endmodule
